// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encodings and defaults for the memory-port arbiter and its watchdog.
// Used by both the default build and the ARB_TIMEOUT_EN build.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_IF     = 3'd1,
    S_DEC    = 3'd2,
    S_MEM    = 3'd3,
    S_COMMIT = 3'd4,
    S_HALT   = 3'd5
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // States in which the arbiter owns the memory bus and holds m_req high.
  function automatic logic is_access(arb_state_t s);
    return (s == S_IF) || (s == S_MEM);
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Ack-wait watchdog: counts stalled request cycles and flags expiry on the last one.
// Only present when ARB_TIMEOUT_EN is defined.
`ifdef ARB_TIMEOUT_EN
module arb_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count_reg;

  // Fires during the TIMEOUT_CYCLES-th stalled cycle so m_req drops right after it.
  assign expired = count_en && (count_reg == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (count_en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Sequences instruction fetch, optional load/store and commit over one shared memory port.
// Define ARB_TIMEOUT_EN to add the ack watchdog, sticky bus_err and the S_HALT trap state.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [DATA_WIDTH-1:0] inst_data,
  input  logic                  d_ren,
  input  logic                  d_wen,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  cpu_en,
  output logic                  busy,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_ack,
  output logic                  bus_err
);

  arb_state_t state_reg, state_next;
  logic       timeout;

`ifdef ARB_TIMEOUT_EN
  logic access_start;
  logic bus_err_reg;

  assign access_start = is_access(state_next) && (state_next != state_reg);

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (access_start),
    .count_en (m_req && !m_ack),
    .expired  (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err_reg <= 1'b0;
    end else if (timeout) begin
      bus_err_reg <= 1'b1;
    end
  end

  assign bus_err = bus_err_reg;
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:   if (run) state_next = S_IF;
      S_IF: begin
        if (timeout)    state_next = S_HALT;
        else if (m_ack) state_next = S_DEC;
      end
      S_DEC:    state_next = (d_wen || d_ren) ? S_MEM : S_COMMIT;
      S_MEM: begin
        if (timeout)    state_next = S_HALT;
        else if (m_ack) state_next = S_COMMIT;
      end
      S_COMMIT: state_next = run ? S_IF : S_IDLE;
      default:  state_next = state_reg;
    endcase
  end

  assign busy = (state_reg != S_IDLE);

  // Bus outputs are loaded from the next state so they are stable for the whole request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      inst_data <= '0;
      mem_din   <= '0;
      cpu_en    <= 1'b0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
    end else begin
      state_reg <= state_next;
      cpu_en    <= (state_next == S_COMMIT);
      m_req     <= is_access(state_next);
      if (state_next == S_IF && state_reg != S_IF) begin
        m_addr <= inst_addr;
        m_we   <= 1'b0;
      end
      if (state_next == S_MEM && state_reg != S_MEM) begin
        m_addr  <= mem_addr;
        m_we    <= d_wen;
        m_wdata <= mem_dout;
      end
      if (state_reg == S_IF && m_ack && !timeout) begin
        inst_data <= m_rdata;
      end
      // A combined load+store issued as a store, so only a pure read updates mem_din.
      if (state_reg == S_MEM && m_ack && !timeout && !m_we) begin
        mem_din <= m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus randomized instruction mix
// against a transaction-level model (access list, cycle count, captured data).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst, run, d_ren, d_wen, m_ack;
  logic [31:0] inst_addr, mem_addr, mem_dout, m_rdata;
  logic [31:0] inst_data, mem_din, m_addr, m_wdata;
  logic        cpu_en, busy, m_req, m_we, bus_err;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .inst_addr (inst_addr),
    .inst_data (inst_data),
    .d_ren     (d_ren),
    .d_wen     (d_wen),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .cpu_en    (cpu_en),
    .busy      (busy),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_ack     (m_ack),
    .bus_err   (bus_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: per-access latency and read data come from queues; each completed
  // access is logged so the bench can compare it with the expected access list.
  int          lat_q[$];
  logic [31:0] rd_q[$];
  logic        acc_we_q[$];
  logic [31:0] acc_addr_q[$];
  logic [31:0] acc_wd_q[$];
  int          wait_cnt = 0;
  int          cur_lat = 0;
  int          unstable = 0;
  logic [31:0] cur_rd, st_addr, st_wd, always_rd;
  logic        st_we;
  logic        ack_always = 1'b0;

  always @(negedge clk) begin
    if (ack_always) begin
      m_ack    = 1'b1;
      m_rdata  = always_rd;
      wait_cnt = 0;
    end else if (m_req) begin
      if (wait_cnt == 0) begin
        cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 100000;
        cur_rd  = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hBAD0_BAD0;
        st_addr = m_addr;
        st_we   = m_we;
        st_wd   = m_wdata;
      end else if (m_addr !== st_addr || m_we !== st_we || m_wdata !== st_wd) begin
        unstable++;
      end
      wait_cnt++;
      if (wait_cnt == cur_lat) begin
        m_ack   = 1'b1;
        m_rdata = cur_rd;
        acc_we_q.push_back(m_we);
        acc_addr_q.push_back(m_addr);
        acc_wd_q.push_back(m_wdata);
      end else begin
        m_ack   = 1'b0;
        m_rdata = $urandom;
      end
    end else begin
      wait_cnt = 0;
      m_ack    = 1'b0;
      m_rdata  = $urandom;
    end
  end

  logic [31:0] exp_mem_din = 32'h0;
  int          instr_no = 0;

  // Precondition: the next rising edge enters instruction fetch.
  task automatic run_instr(input int a1, input int a2, input logic ren, input logic wen,
                           input logic [31:0] iaddr, input logic [31:0] idata,
                           input logic [31:0] maddr, input logic [31:0] mdout,
                           input logic [31:0] rdata2, input bit drop_run);
    int   cyc;
    int   exp_cyc;
    logic has_mem;
    has_mem = ren | wen;
    lat_q.push_back(a1);
    rd_q.push_back(idata);
    if (has_mem) begin
      lat_q.push_back(a2);
      rd_q.push_back(rdata2);
    end
    inst_addr = iaddr;
    d_ren     = ren;
    d_wen     = wen;
    mem_addr  = maddr;
    mem_dout  = mdout;
    exp_cyc   = has_mem ? (a1 + a2 + 2) : (a1 + 2);

    @(posedge clk); #1;
    check("req_rise", m_req, 1);
    check("cpu_en_low_at_fetch", cpu_en, 0);
    cyc = 0;
    while (!cpu_en && cyc < 400) begin
      if (drop_run && cyc == a1 + 1) run = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check("instr_cycles", cyc + 1, exp_cyc);
    check("inst_data", inst_data, idata);
    if (ren && !wen) exp_mem_din = rdata2;
    check("mem_din", mem_din, exp_mem_din);
    check("busy_at_commit", busy, 1);
    check("access_count", acc_we_q.size(), has_mem ? 2 : 1);
    if (acc_we_q.size() > 0) begin
      check("fetch_we", acc_we_q.pop_front(), 0);
      check("fetch_addr", acc_addr_q.pop_front(), iaddr);
      void'(acc_wd_q.pop_front());
    end
    if (has_mem && acc_we_q.size() > 0) begin
      check("data_we", acc_we_q.pop_front(), wen);
      check("data_addr", acc_addr_q.pop_front(), maddr);
      if (wen) check("data_wdata", acc_wd_q.pop_front(), mdout);
      else void'(acc_wd_q.pop_front());
    end
    acc_we_q.delete();
    acc_addr_q.delete();
    acc_wd_q.delete();
    instr_no++;
    $display("instr %0d ren=%0b wen=%0b a1=%0d a2=%0d cycles=%0d inst_data=%08h mem_din=%08h",
             instr_no, ren, wen, a1, a2, cyc + 1, inst_data, mem_din);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int          hi;
    int          kind;
    logic [31:0] ia;
    rst = 1'b1; run = 1'b1; d_ren = 1'b0; d_wen = 1'b0;
    inst_addr = '0; mem_addr = '0; mem_dout = '0;
    ack_always = 1'b1; always_rd = 32'hFFFF_FFFF;

    // Reset with run high and memory acking: everything stays quiet.
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_m_req", m_req, 0);
      check("rst_cpu_en", cpu_en, 0);
      check("rst_busy", busy, 0);
      check("rst_inst_data", inst_data, 0);
      check("rst_mem_din", mem_din, 0);
      check("rst_m_we", m_we, 0);
      check("rst_m_addr", m_addr, 0);
      check("rst_m_wdata", m_wdata, 0);
      check("rst_bus_err", bus_err, 0);
    end
    rst = 1'b0;
    ack_always = 1'b0;

    // ALU, load, and load+store (store wins) directed instructions.
    run_instr(1, 0, 1'b0, 1'b0, 32'h0, 32'h0022_1820, 32'h0, 32'h0, 32'h0, 1'b0);
    run_instr(3, 3, 1'b1, 1'b0, 32'h4, 32'h8C01_0040, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0);
    run_instr(2, 2, 1'b1, 1'b1, 32'h8, 32'hAC02_0080, 32'h80, 32'h1234_5678, 32'h55AA_55AA, 1'b0);

    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 3);
      ia   = $urandom & 32'hFFFF_FFFC;
      run_instr($urandom_range(1, 4), $urandom_range(1, 4), kind[0], kind[1], ia, $urandom,
                $urandom, $urandom, $urandom, 1'b0);
    end

    // run falls while the load is in flight: one commit, then idle.
    run_instr(2, 3, 1'b1, 1'b0, 32'h100, 32'h8C03_0010, 32'h200, 32'h0, 32'h0BAD_CAFE, 1'b1);
    @(posedge clk); #1;
    check("halt_busy", busy, 0);
    check("halt_m_req", m_req, 0);
    check("halt_cpu_en", cpu_en, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_m_req", m_req, 0);
      check("idle_busy", busy, 0);
    end
    run = 1'b1;
    run_instr(1, 0, 1'b0, 1'b0, 32'h104, 32'h0000_0020, 32'h0, 32'h0, 32'h0, 1'b0);

    // Reset while waiting for a fetch ack; a later stray ack must be ignored.
    lat_q.push_back(10);
    rd_q.push_back(32'h1111_1111);
    inst_addr = 32'h108;
    d_ren = 1'b0; d_wen = 1'b0;
    @(posedge clk); #1;
    check("abort_req_rise", m_req, 1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    check("abort_m_req", m_req, 0);
    check("abort_busy", busy, 0);
    check("abort_inst_data", inst_data, 0);
    check("abort_mem_din", mem_din, 0);
    rst = 1'b0;
    exp_mem_din = 32'h0;
    always_rd = 32'hCAFE_F00D;
    ack_always = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("stray_ack_inst_data", inst_data, 0);
      check("stray_ack_busy", busy, 0);
    end
    ack_always = 1'b0;
    acc_we_q.delete(); acc_addr_q.delete(); acc_wd_q.delete();
    run = 1'b1;
    run_instr(2, 1, 1'b1, 1'b0, 32'h0, 32'h8C04_0000, 32'h44, 32'h0, 32'h7777_8888, 1'b0);

    // Memory never acks.
    lat_q.push_back(100000);
    rd_q.push_back(32'h0);
    inst_addr = 32'h10C;
    d_ren = 1'b0; d_wen = 1'b0;
    @(posedge clk); #1;
    check("stall_req_rise", m_req, 1);
`ifdef ARB_TIMEOUT_EN
    hi = 1;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      if (!m_req) break;
      hi++;
    end
    check("timeout_req_cycles", hi, mem_port_arbiter_pkg::DEFAULT_TIMEOUT_CYCLES);
    repeat (3) begin
      check("timeout_bus_err", bus_err, 1);
      check("timeout_busy", busy, 1);
      check("timeout_cpu_en", cpu_en, 0);
      check("timeout_m_req", m_req, 0);
      @(posedge clk); #1;
    end
`else
    hi = 1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (m_req) hi++;
    end
    check("stall_req_held", hi, 41);
    check("stall_bus_err", bus_err, 0);
    check("stall_cpu_en", cpu_en, 0);
    check("stall_busy", busy, 1);
`endif
    rst = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    check("post_rst_bus_err", bus_err, 0);
    check("post_rst_m_req", m_req, 0);
    check("post_rst_busy", busy, 0);
    rst = 1'b0;

    check("bus_fields_stable", unstable, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
